// File: rtl/stream_demux_if.sv
// -----------------------------------------------------------------------------
// stream_demux_if
// Bundles the upstream stream, the per-channel downstream streams and the
// status outputs of stream_demux into one interface.
//
// Signals
//   inValid  upstream word present
//   inReady  demux accepts the word this cycle
//   inData   upstream word (BITS_SIZE bits)
//   inSel    destination channel index (clog2(CHANNELS) bits)
//   outValid bit k: channel k head word valid
//   outReady bit k: channel k consumer takes the head word
//   outData  channel k head word at [k*BITS_SIZE +: BITS_SIZE]
//   dropErr  sticky flag, a word for a nonexistent channel was discarded
//   chCount  per-channel 16-bit accepted-word counters
//
// Modports
//   slave  : the demux itself
//   master : the environment driving the upstream side and consuming channels
// -----------------------------------------------------------------------------
interface stream_demux_if #(
  parameter int BITS_SIZE = 64,
  parameter int CHANNELS  = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                          inValid;
  logic                          inReady;
  logic [BITS_SIZE-1:0]          inData;
  logic [SEL_W-1:0]              inSel;
  logic [CHANNELS-1:0]           outValid;
  logic [CHANNELS-1:0]           outReady;
  logic [CHANNELS*BITS_SIZE-1:0] outData;
  logic                          dropErr;
  logic [CHANNELS*16-1:0]        chCount;

  modport slave (
    input  inValid, inData, inSel, outReady,
    output inReady, outValid, outData, dropErr, chCount
  );

  modport master (
    output inValid, inData, inSel, outReady,
    input  inReady, outValid, outData, dropErr, chCount
  );
endinterface

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Routes each upstream word to one of CHANNELS output streams selected by
// inSel. Every channel owns an independent DEPTH-entry FIFO. Words addressed
// to a channel index >= CHANNELS are accepted, discarded and flagged on the
// sticky dropErr output.
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    stream_demux_if.slave (upstream, downstream channels, status)
//
// Parameters
//   BITS_SIZE  data word width
//   CHANNELS   number of output channels (2..16)
//   DEPTH      per-channel FIFO depth, power of two (2..16)
//
// Optional feature
//   STREAM_DEMUX_COUNT_EN  when defined, chCount holds saturating per-channel
//                          accepted-word counters; otherwise chCount is 0.
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter int BITS_SIZE = 64,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 4
) (
  input logic           clk,
  input logic           rst_n,
  stream_demux_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [BITS_SIZE-1:0] mem_q    [CHANNELS][DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q [CHANNELS];
  logic [PTR_W-1:0]     rd_ptr_d [CHANNELS];
  logic [PTR_W-1:0]     wr_ptr_q [CHANNELS];
  logic [PTR_W-1:0]     wr_ptr_d [CHANNELS];
  logic [OCC_W-1:0]     occ_q    [CHANNELS];
  logic [OCC_W-1:0]     occ_d    [CHANNELS];
  logic                 drop_err_q;
  logic                 drop_err_d;

  logic                          in_ready;
  logic                          sel_hit;
  logic [CHANNELS-1:0]           push;
  logic [CHANNELS-1:0]           pop;
  logic [CHANNELS-1:0]           out_valid;
  logic [CHANNELS*BITS_SIZE-1:0] out_data;

  // Channel lookup is done by comparison rather than indexing so an
  // out-of-range inSel never indexes past the channel arrays.
  always_comb begin
    in_ready   = 1'b1;
    sel_hit    = 1'b0;
    push       = '0;
    pop        = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(bus.inSel) == k) begin
        sel_hit  = 1'b1;
        in_ready = (occ_q[k] != OCC_FULL);
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      push[k] = bus.inValid && in_ready && (int'(bus.inSel) == k);
      pop[k]  = (occ_q[k] != '0) && bus.outReady[k];
    end
    // in_ready is always 1 for an unmatched index, so inValid alone accepts it.
    drop_err_d = drop_err_q | (bus.inValid && !sel_hit);
    for (int k = 0; k < CHANNELS; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop[k]);
      occ_d[k]    = occ_q[k] + OCC_W'(push[k]) - OCC_W'(pop[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        occ_q[k]    <= '0;
      end
    end else begin
      drop_err_q <= drop_err_d;
      for (int k = 0; k < CHANNELS; k++) begin
        rd_ptr_q[k] <= rd_ptr_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        occ_q[k]    <= occ_d[k];
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= bus.inData;
      end
    end
  end

  // Empty channels present all-zero data so stale storage never leaks out.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      out_valid[k] = (occ_q[k] != '0);
      if (out_valid[k]) begin
        out_data[k*BITS_SIZE +: BITS_SIZE] = mem_q[k][rd_ptr_q[k]];
      end
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.outData  = out_data;
  assign bus.dropErr  = drop_err_q;

`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0]            cnt_q [CHANNELS];
  logic [15:0]            cnt_d [CHANNELS];
  logic [CHANNELS*16-1:0] ch_count;

  always_comb begin
    ch_count = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_d[k] = (push[k] && (cnt_q[k] != 16'hFFFF)) ? cnt_q[k] + 16'd1 : cnt_q[k];
      ch_count[k*16 +: 16] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.chCount = ch_count;
`else
  assign bus.chCount = '0;
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter BITS_SIZE, default 64, SHALL set the data word width.
REQ-002 Parameter CHANNELS, default 4, range 2..16, SHALL set the number of output channels.
REQ-003 Parameter DEPTH, default 4, power of two, range 2..16, SHALL set the per-channel buffer depth in words.
REQ-004 Derived SEL_W = clog2(CHANNELS) SHALL size inSel.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 inValid  in  1  upstream word present.
REQ-008 inReady  out  1  block accepts the word this cycle.
REQ-009 inData  in  BITS_SIZE  upstream word.
REQ-010 inSel  in  SEL_W  destination channel index, sampled with inData.
REQ-011 outValid  out  CHANNELS  bit k: channel k head word valid.
REQ-012 outReady  in  CHANNELS  bit k: channel k consumer takes the head word.
REQ-013 outData  out  CHANNELS*BITS_SIZE  channel k head word at bits [k*BITS_SIZE +: BITS_SIZE].
REQ-014 dropErr  out  1  sticky flag: a word addressed to a nonexistent channel was discarded.
REQ-015 chCount  out  CHANNELS*16  per-channel accepted-word counters (see Configuration).

Function
REQ-016 Transfer in SHALL occur on a rising edge when inValid && inReady.
REQ-017 Transfer out on channel k SHALL occur on a rising edge when outValid[k] && outReady[k].
REQ-018 Each channel SHALL own an independent DEPTH-entry FIFO with read pointer, write pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-019 inReady SHALL be combinational: 1 when inSel >= CHANNELS; otherwise 1 iff the selected FIFO holds fewer than DEPTH words. It SHALL NOT depend on outReady, so there is no same-cycle pass-through when full.
REQ-020 An accepted word with inSel < CHANNELS SHALL be written only to FIFO inSel; all other FIFOs are unchanged.
REQ-021 An accepted word with inSel >= CHANNELS SHALL be discarded and dropErr set to 1 on that edge; dropErr stays 1 until reset.
REQ-022 Latency: a word accepted into an empty FIFO at edge N SHALL assert outValid on the cycle after edge N, with data on outData.
REQ-023 outValid[k] SHALL equal (occupancy_k != 0). outData slice k SHALL show the head word when valid and all-zero when empty; tri-state values SHALL NOT be driven.
REQ-024 A simultaneous push and pop on the same non-empty channel SHALL leave occupancy unchanged and preserve FIFO order.
REQ-025 Pops on different channels in the same cycle SHALL be independent. outReady[k] with outValid[k]=0 SHALL have no effect.
REQ-026 Words SHALL leave each channel in acceptance order. No word is duplicated, and a word is lost only by the drop rule in REQ-021.

Reset
REQ-027 rst_n low SHALL, immediately and regardless of clk, clear all pointers, occupancies, dropErr and chCount, forcing outValid=0 and outData=0.
REQ-028 Reset asserted mid-transfer SHALL discard all buffered words. Operation SHALL resume on the first rising edge after rst_n returns high.
REQ-029 FIFO storage arrays need not be reset.

Configuration
REQ-030 With macro STREAM_DEMUX_COUNT_EN defined, each chCount slice k SHALL increment by 1 on every word accepted into channel k and saturate at 16'hFFFF.
REQ-031 Without STREAM_DEMUX_COUNT_EN, the counter logic SHALL be absent, chCount SHALL be driven constant 0, and the port list SHALL be unchanged.

Verification
REQ-032 Reset, then inValid=1, inSel=2, inData=64'hA5 -> inReady=1, next cycle outValid=4'b0100 and slice 2 = 64'hA5.
REQ-033 Hold outReady=0, push 5 words to channel 1 (DEPTH=4) -> inReady=0 on the 5th; release outReady[1] -> 4 words exit in order.
REQ-034 Channel 0 holding 2 words, push and pop channel 0 in the same cycle -> occupancy stays 2 and order is preserved.
REQ-035 CHANNELS=3, push with inSel=3 -> inReady=1, no outValid change, dropErr=1 until reset.
REQ-036 Assert rst_n low asynchronously with 3 words buffered -> outValid=0 and dropErr=0 before the next edge; after release, an empty channel accepts DEPTH words.
REQ-037 With STREAM_DEMUX_COUNT_EN defined, push 70000 words to channel 0 -> chCount slice 0 = 16'hFFFF; with it undefined -> chCount = 0.
